// File: rtl/cues_sync_receiver_pkg.sv
// cues_rx_pkg: shared types and sizing helpers for the CUES synchronous receiver
package cues_rx_pkg;
   typedef enum logic [1:0] {WAIT_LOW, IDLE, ACKED} rx_state_t;
   localparam int TOKEN_W = 16;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/cues_sync_receiver_if.sv
// cues_sync_receiver_if: upstream 4-phase bundled-data handshake plus downstream valid/ready port
interface cues_sync_receiver_if #(
   parameter int DATA_W = 8
);
   logic              sendin;
   logic [DATA_W-1:0] datain;
   logic              ackout;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   modport master (output sendin, datain, dout_ready, input ackout, dout, dout_valid);
   modport slave  (input sendin, datain, dout_ready, output ackout, dout, dout_valid);
endinterface

// File: rtl/cues_sync_receiver_fifo.sv
// cues_rx_fifo: synchronous first-word-fall-through FIFO with extra-MSB pointers
module cues_rx_fifo
   import cues_rx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0] wp, rp;
   assign empty = wp == rp;
   assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
   assign dout  = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk)
      if (push && !full) mem[wp[AW-1:0]] <= din;
   always_ff @(posedge clk) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full) wp <= wp + PW'(1);
         if (pop && !empty) rp <= rp + PW'(1);
      end
   end
   assert property (@(posedge clk) disable iff (reset) !(push && full));
endmodule

// File: rtl/cues_sync_receiver.sv
// cues_sync_receiver: clocked endpoint for a self-timed CUES pipeline; syncs SENDIN,
// acknowledges each 4-phase token once and buffers its data in a FWFT FIFO.
module cues_sync_receiver
   import cues_rx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   cues_sync_receiver_if.slave bus,
   output logic [TOKEN_W-1:0]  token_cnt
);
   logic [SYNC_STAGES-1:0] sync, primed;
   logic send_s, full, empty, push, ackout;
   rx_state_t state;
   assign send_s         = sync[SYNC_STAGES-1];
   assign push           = state == IDLE && send_s && !full;
   assign bus.ackout     = ackout;
   assign bus.dout_valid = !empty;
   // primed marks when send_s reflects a post-reset sample, so a SENDIN held
   // high across reset cannot masquerade as a low phase
   always_ff @(posedge clk) begin
      sync   <= reset ? '0 : {sync[SYNC_STAGES-2:0], bus.sendin};
      primed <= reset ? '0 : {primed[SYNC_STAGES-2:0], 1'b1};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= WAIT_LOW;
         ackout    <= 1'b0;
         token_cnt <= '0;
      end else begin
         if (push) token_cnt <= token_cnt + TOKEN_W'(1);
         case (state)
            WAIT_LOW: if (primed[SYNC_STAGES-1] && !send_s) state <= IDLE;
            IDLE: if (push) begin
               state  <= ACKED;
               ackout <= 1'b1;
            end
            ACKED: if (!send_s) begin
               state  <= IDLE;
               ackout <= 1'b0;
            end
            default: state <= WAIT_LOW;
         endcase
      end
   end
   cues_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (bus.dout_ready && !empty),
      .din   (bus.datain),
      .dout  (bus.dout),
      .full  (full),
      .empty (empty)
   );
endmodule
